// File: rtl/rename_dispatch_unit.sv
// Register rename and dispatch: RAT with spec/tag per architectural register, circular tag allocator, IIQ/LSQ steering.
// Optional macro RENAME_RETIRE_BYPASS_EN: sources cleared by a same-cycle retire are dispatched as non-speculative.
module rename_dispatch_unit #(
    parameter int ARCH_REGS     = 32,
    parameter int ROB_DEPTH     = 16,
    parameter int PAYLOAD_WIDTH = 64,
    localparam int REG_W        = $clog2(ARCH_REGS),
    localparam int TAG_W        = $clog2(ROB_DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst_aL,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [REG_W-1:0]         in_rs1,
    input  logic [REG_W-1:0]         in_rs2,
    input  logic [REG_W-1:0]         in_rd,
    input  logic                     in_rs1_en,
    input  logic                     in_rs2_en,
    input  logic                     in_rd_en,
    input  logic                     in_is_lsq,
    input  logic [PAYLOAD_WIDTH-1:0] in_payload,
    output logic                     iiq_dispatch_valid,
    input  logic                     iiq_dispatch_ready,
    output logic                     lsq_dispatch_valid,
    input  logic                     lsq_dispatch_ready,
    output logic [TAG_W-1:0]         disp_tag,
    output logic                     disp_rs1_spec,
    output logic [TAG_W-1:0]         disp_rs1_tag,
    output logic                     disp_rs2_spec,
    output logic [TAG_W-1:0]         disp_rs2_tag,
    output logic [PAYLOAD_WIDTH-1:0] disp_payload,
    input  logic                     retire_valid,
    input  logic [REG_W-1:0]         retire_rd,
    input  logic                     retire_rd_en,
    output logic [TAG_W-1:0]         retire_tag,
    input  logic                     flush,
    output logic [TAG_W:0]           rob_count
);

    logic [ARCH_REGS-1:0] r_spec;
    logic [TAG_W-1:0]     r_tag [ARCH_REGS];
    logic [TAG_W-1:0]     r_head;
    logic [TAG_W-1:0]     r_tail;
    logic [TAG_W:0]       r_count;

    logic w_queueReady;
    logic w_fire;
    logic w_rename;
    logic w_retAccept;
    logic w_retClear;

    // Count never exceeds ROB_DEPTH (a power of two), so its MSB alone means full.
    assign w_queueReady = in_is_lsq ? lsq_dispatch_ready : iiq_dispatch_ready;
    assign in_ready     = ~r_count[TAG_W] & ~flush & w_queueReady;
    assign w_fire       = in_valid & in_ready;
    assign w_rename     = w_fire & in_rd_en & (in_rd != '0);
    assign w_retAccept  = retire_valid & (r_count != '0) & ~flush;
    assign w_retClear   = w_retAccept & retire_rd_en & (retire_rd != '0) & r_spec[retire_rd]
                        & (r_tag[retire_rd] == r_head) & ~(w_rename & (in_rd == retire_rd));

    assign iiq_dispatch_valid = in_valid & ~in_is_lsq & in_ready;
    assign lsq_dispatch_valid = in_valid & in_is_lsq & in_ready;
    assign disp_tag           = r_tail;
    assign disp_payload       = in_payload;
    assign retire_tag         = r_head;
    assign rob_count          = r_count;

    always_comb begin
        disp_rs1_spec = 1'b0;
        disp_rs1_tag  = '0;
        disp_rs2_spec = 1'b0;
        disp_rs2_tag  = '0;
        if (in_rs1_en && in_rs1 != '0 && r_spec[in_rs1]) begin
            disp_rs1_spec = 1'b1;
            disp_rs1_tag  = r_tag[in_rs1];
        end
        if (in_rs2_en && in_rs2 != '0 && r_spec[in_rs2]) begin
            disp_rs2_spec = 1'b1;
            disp_rs2_tag  = r_tag[in_rs2];
        end
`ifdef RENAME_RETIRE_BYPASS_EN
        // The producer is retiring right now, so its value is already architectural.
        if (w_retClear && in_rs1 == retire_rd) begin
            disp_rs1_spec = 1'b0;
            disp_rs1_tag  = '0;
        end
        if (w_retClear && in_rs2 == retire_rd) begin
            disp_rs2_spec = 1'b0;
            disp_rs2_tag  = '0;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_aL) begin
        if (!rst_aL) begin
            r_spec  <= '0;
            for (int i = 0; i < ARCH_REGS; i++) r_tag[i] <= '0;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_spec  <= '0;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_fire)      r_tail <= r_tail + TAG_W'(1);
            if (w_retAccept) r_head <= r_head + TAG_W'(1);
            if (w_retClear)  r_spec[retire_rd] <= 1'b0;
            if (w_rename) begin
                r_spec[in_rd] <= 1'b1;
                r_tag[in_rd]  <= r_tail;
            end
            case ({w_fire, w_retAccept})
                2'b10:   r_count <= r_count + (TAG_W+1)'(1);
                2'b01:   r_count <= r_count - (TAG_W+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: tb/tb_rename_dispatch_unit.sv
// Directed bench for rename_dispatch_unit with hand-computed expectations (default parameters).
module tb_rename_dispatch_unit;

    logic        clk;
    logic        rst_aL;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_rs1, in_rs2, in_rd;
    logic        in_rs1_en, in_rs2_en, in_rd_en;
    logic        in_is_lsq;
    logic [63:0] in_payload;
    logic        iiq_dispatch_valid, iiq_dispatch_ready;
    logic        lsq_dispatch_valid, lsq_dispatch_ready;
    logic [3:0]  disp_tag;
    logic        disp_rs1_spec, disp_rs2_spec;
    logic [3:0]  disp_rs1_tag, disp_rs2_tag;
    logic [63:0] disp_payload;
    logic        retire_valid;
    logic [4:0]  retire_rd;
    logic        retire_rd_en;
    logic [3:0]  retire_tag;
    logic        flush;
    logic [4:0]  rob_count;

    int compared   = 0;
    int mismatched = 0;

    rename_dispatch_unit dut (
        .clk(clk), .rst_aL(rst_aL),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
        .in_rs1_en(in_rs1_en), .in_rs2_en(in_rs2_en), .in_rd_en(in_rd_en),
        .in_is_lsq(in_is_lsq), .in_payload(in_payload),
        .iiq_dispatch_valid(iiq_dispatch_valid), .iiq_dispatch_ready(iiq_dispatch_ready),
        .lsq_dispatch_valid(lsq_dispatch_valid), .lsq_dispatch_ready(lsq_dispatch_ready),
        .disp_tag(disp_tag),
        .disp_rs1_spec(disp_rs1_spec), .disp_rs1_tag(disp_rs1_tag),
        .disp_rs2_spec(disp_rs2_spec), .disp_rs2_tag(disp_rs2_tag),
        .disp_payload(disp_payload),
        .retire_valid(retire_valid), .retire_rd(retire_rd), .retire_rd_en(retire_rd_en),
        .retire_tag(retire_tag), .flush(flush), .rob_count(rob_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] observed, input logic [63:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: observed %0h expected %0h", name, observed, expected);
        end
    endtask

    // Drives one dispatch slot; outputs are settled and sampled 1ns later, well before the next edge.
    task automatic applyStimulus(input logic valid, input logic isLsq,
                                 input logic rs1En, input logic [4:0] rs1,
                                 input logic rs2En, input logic [4:0] rs2,
                                 input logic rdEn,  input logic [4:0] rd);
        in_valid   = valid;
        in_is_lsq  = isLsq;
        in_rs1_en  = rs1En;
        in_rs1     = rs1;
        in_rs2_en  = rs2En;
        in_rs2     = rs2;
        in_rd_en   = rdEn;
        in_rd      = rd;
        in_payload = {32'hCAFE0000, 27'd0, rd};
        #1;
    endtask

    task automatic setRetire(input logic valid, input logic rdEn, input logic [4:0] rd);
        retire_valid = valid;
        retire_rd_en = rdEn;
        retire_rd    = rd;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_aL             = 1'b0;
        flush              = 1'b0;
        iiq_dispatch_ready = 1'b1;
        lsq_dispatch_ready = 1'b1;
        setRetire(1'b0, 1'b0, 5'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd4);

        // Reset held across edges with a valid instruction present
        nextCycle();
        nextCycle();
        checkOutput("reset_count", 64'(rob_count), 64'd0);
        checkOutput("reset_retire_tag", 64'(retire_tag), 64'd0);
        checkOutput("reset_disp_tag", 64'(disp_tag), 64'd0);
        rst_aL = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b1, 5'd4, 1'b0, 5'd0, 1'b0, 5'd0);
        checkOutput("release_rs1_spec", 64'(disp_rs1_spec), 64'd0);

        // Rename rd=5, then consume it
        applyStimulus(1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd5);
        checkOutput("a1_disp_tag", 64'(disp_tag), 64'd0);
        checkOutput("a1_iiq_valid", 64'(iiq_dispatch_valid), 64'd1);
        checkOutput("a1_lsq_valid", 64'(lsq_dispatch_valid), 64'd0);
        checkOutput("a1_payload", disp_payload, 64'hCAFE0000_00000005);
        nextCycle();
        checkOutput("a1_count", 64'(rob_count), 64'd1);
        applyStimulus(1'b1, 1'b0, 1'b1, 5'd5, 1'b0, 5'd0, 1'b0, 5'd0);
        checkOutput("a2_rs1_spec", 64'(disp_rs1_spec), 64'd1);
        checkOutput("a2_rs1_tag", 64'(disp_rs1_tag), 64'd0);
        checkOutput("a2_disp_tag", 64'(disp_tag), 64'd1);
        nextCycle();

        // Destination x0 consumes a tag but never becomes speculative
        applyStimulus(1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd0);
        checkOutput("b_disp_tag", 64'(disp_tag), 64'd2);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 1'b1, 5'd0, 1'b0, 5'd5, 1'b0, 5'd0);
        checkOutput("b_count", 64'(rob_count), 64'd3);
        checkOutput("b_rs1_x0_spec", 64'(disp_rs1_spec), 64'd0);
        checkOutput("b_rs2_disabled_spec", 64'(disp_rs2_spec), 64'd0);

        // Four in flight, then flush
        applyStimulus(1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd9);
        checkOutput("c_disp_tag", 64'(disp_tag), 64'd3);
        nextCycle();
        checkOutput("c_count", 64'(rob_count), 64'd4);
        flush = 1'b1;
        setRetire(1'b1, 1'b0, 5'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd9);
        checkOutput("c_flush_ready", 64'(in_ready), 64'd0);
        checkOutput("c_flush_iiq_valid", 64'(iiq_dispatch_valid), 64'd0);
        nextCycle();
        flush = 1'b0;
        setRetire(1'b0, 1'b0, 5'd0);
        applyStimulus(1'b0, 1'b0, 1'b1, 5'd5, 1'b1, 5'd9, 1'b0, 5'd0);
        checkOutput("c_post_count", 64'(rob_count), 64'd0);
        checkOutput("c_post_rs1_spec", 64'(disp_rs1_spec), 64'd0);
        checkOutput("c_post_rs2_spec", 64'(disp_rs2_spec), 64'd0);
        checkOutput("c_post_disp_tag", 64'(disp_tag), 64'd0);

        // Retire on an empty window is ignored
        setRetire(1'b1, 1'b0, 5'd0);
        nextCycle();
        setRetire(1'b0, 1'b0, 5'd0);
        #1;
        checkOutput("empty_retire_count", 64'(rob_count), 64'd0);
        checkOutput("empty_retire_tag", 64'(retire_tag), 64'd0);

        // LSQ back-pressure blocks only LSQ instructions
        lsq_dispatch_ready = 1'b0;
        applyStimulus(1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd3);
        checkOutput("d_iiq_ready", 64'(in_ready), 64'd1);
        applyStimulus(1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd3);
        checkOutput("d_lsq_ready", 64'(in_ready), 64'd0);
        checkOutput("d_lsq_valid", 64'(lsq_dispatch_valid), 64'd0);
        nextCycle();
        checkOutput("d_count", 64'(rob_count), 64'd0);
        checkOutput("d_disp_tag", 64'(disp_tag), 64'd0);
        lsq_dispatch_ready = 1'b1;

        // rd=3 renamed twice; retiring the older tag leaves the newer mapping
        applyStimulus(1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd3);
        checkOutput("e_lsq_valid", 64'(lsq_dispatch_valid), 64'd1);
        checkOutput("e_iiq_valid", 64'(iiq_dispatch_valid), 64'd0);
        nextCycle();
        applyStimulus(1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd3);
        checkOutput("e_disp_tag", 64'(disp_tag), 64'd1);
        nextCycle();
        setRetire(1'b1, 1'b1, 5'd3);
        applyStimulus(1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0);
        checkOutput("e_retire_tag0", 64'(retire_tag), 64'd0);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 1'b1, 5'd3, 1'b0, 5'd0, 1'b0, 5'd0);
        checkOutput("e_count", 64'(rob_count), 64'd1);
        checkOutput("e_rs1_spec", 64'(disp_rs1_spec), 64'd1);
        checkOutput("e_rs1_tag", 64'(disp_rs1_tag), 64'd1);
        checkOutput("e_retire_tag1", 64'(retire_tag), 64'd1);
        nextCycle();
        setRetire(1'b0, 1'b0, 5'd0);
        #1;
        checkOutput("e_cleared_spec", 64'(disp_rs1_spec), 64'd0);
        checkOutput("e_cleared_count", 64'(rob_count), 64'd0);

        // Retire of tag 2 (rd=7) in the same cycle as a reader of x7
        applyStimulus(1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd7);
        checkOutput("f_disp_tag", 64'(disp_tag), 64'd2);
        nextCycle();
        setRetire(1'b1, 1'b1, 5'd7);
        applyStimulus(1'b1, 1'b0, 1'b0, 5'd0, 1'b1, 5'd7, 1'b0, 5'd0);
`ifdef RENAME_RETIRE_BYPASS_EN
        checkOutput("f_rs2_spec", 64'(disp_rs2_spec), 64'd0);
`else
        checkOutput("f_rs2_spec", 64'(disp_rs2_spec), 64'd1);
        checkOutput("f_rs2_tag", 64'(disp_rs2_tag), 64'd2);
`endif
        checkOutput("f_disp_tag3", 64'(disp_tag), 64'd3);
        nextCycle();
        setRetire(1'b0, 1'b0, 5'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 5'd7, 1'b0, 5'd0);
        checkOutput("f_count", 64'(rob_count), 64'd1);
        checkOutput("f_rs2_cleared", 64'(disp_rs2_spec), 64'd0);
        checkOutput("f_retire_tag", 64'(retire_tag), 64'd3);

        // Rename of the retiring register wins over the clear
        setRetire(1'b1, 1'b0, 5'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd7);
        nextCycle();
        setRetire(1'b1, 1'b1, 5'd7);
        applyStimulus(1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd7);
        checkOutput("g_retire_tag", 64'(retire_tag), 64'd4);
        checkOutput("g_disp_tag", 64'(disp_tag), 64'd5);
        nextCycle();
        setRetire(1'b0, 1'b0, 5'd0);
        applyStimulus(1'b0, 1'b0, 1'b1, 5'd7, 1'b0, 5'd0, 1'b0, 5'd0);
        checkOutput("g_count", 64'(rob_count), 64'd1);
        checkOutput("g_rs1_spec", 64'(disp_rs1_spec), 64'd1);
        checkOutput("g_rs1_tag", 64'(disp_rs1_tag), 64'd5);

        // Fill the window, retire one, wrap the tail
        flush = 1'b1;
        nextCycle();
        flush = 1'b0;
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0);
            checkOutput($sformatf("h_fill_tag%0d", i), 64'(disp_tag), 64'(i));
            nextCycle();
        end
        applyStimulus(1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0);
        checkOutput("h_full_count", 64'(rob_count), 64'd16);
        checkOutput("h_full_ready", 64'(in_ready), 64'd0);
        nextCycle();
        checkOutput("h_full_hold", 64'(rob_count), 64'd16);
        setRetire(1'b1, 1'b0, 5'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0);
        checkOutput("h_full_ready_retire", 64'(in_ready), 64'd0);
        nextCycle();
        setRetire(1'b0, 1'b0, 5'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd8);
        checkOutput("h_after_retire_count", 64'(rob_count), 64'd15);
        checkOutput("h_after_retire_tag", 64'(retire_tag), 64'd1);
        checkOutput("h_wrap_tag", 64'(disp_tag), 64'd0);
        checkOutput("h_wrap_ready", 64'(in_ready), 64'd1);
        nextCycle();
        checkOutput("h_refill_count", 64'(rob_count), 64'd16);

        // Asynchronous reset mid-stream
        rst_aL = 1'b0;
        applyStimulus(1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd8);
        checkOutput("r_async_count", 64'(rob_count), 64'd0);
        nextCycle();
        rst_aL = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b1, 5'd8, 1'b0, 5'd0, 1'b0, 5'd0);
        checkOutput("r_release_count", 64'(rob_count), 64'd0);
        checkOutput("r_release_disp_tag", 64'(disp_tag), 64'd0);
        checkOutput("r_release_rs1_spec", 64'(disp_rs1_spec), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
